// File: rtl/seq_alu_if.sv
// ============================================================================
// Module   : seq_alu_if
// Brief    : Start/done handshake, operand and result bundle for seq_alu.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface seq_alu_if #(
   parameter int WIDTH = 16
);
   logic             start;
   logic [3:0]       CTRL;
   logic [WIDTH-1:0] MUX_intop;
   logic [WIDTH-1:0] MUX_inbottom;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] ALU_Result;
   logic [WIDTH-1:0] Remainder;
   logic             Overflow_flag;
   logic             DivZero_flag;
   logic             Illegal_flag;
   logic             Halted;

   modport master (
      output start, CTRL, MUX_intop, MUX_inbottom,
      input  busy, done, ALU_Result, Remainder,
      input  Overflow_flag, DivZero_flag, Illegal_flag, Halted
   );

   modport slave (
      input  start, CTRL, MUX_intop, MUX_inbottom,
      output busy, done, ALU_Result, Remainder,
      output Overflow_flag, DivZero_flag, Illegal_flag, Halted
   );
endinterface

`default_nettype wire

// File: rtl/seq_alu.sv
// ============================================================================
// Module   : seq_alu
// Brief    : Multi-cycle ALU; iterative shift-add MUL / restoring DIV, sticky HALT.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module seq_alu #(
   parameter int WIDTH = 16,
   parameter int SHW   = $clog2(WIDTH)
) (
   input  logic     clk,
   input  logic     rst_n,
   seq_alu_if.slave bus
);

   localparam logic [3:0] c_ADD  = 4'd0;
   localparam logic [3:0] c_SUB  = 4'd1;
   localparam logic [3:0] c_AND  = 4'd2;
   localparam logic [3:0] c_OR   = 4'd3;
   localparam logic [3:0] c_MUL  = 4'd4;
   localparam logic [3:0] c_DIV  = 4'd5;
   localparam logic [3:0] c_SHL  = 4'd6;
   localparam logic [3:0] c_SRA  = 4'd7;
   localparam logic [3:0] c_ROL  = 4'd8;
   localparam logic [3:0] c_ROR  = 4'd9;
   localparam logic [3:0] c_HALT = 4'd10;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_ITER   = 2'd1,
      S_HALTED = 2'd2
   } state_t;

   state_t r_state, w_next;

   logic [WIDTH-1:0] r_result, r_rem, r_b, r_hi, r_lo;
   logic             r_ovf, r_dz, r_ill, r_halted, r_done, r_is_mul;
   logic [SHW-1:0]   r_cnt;

   logic [WIDTH-1:0] w_a, w_bop;
   logic             w_accept, w_iter_op, w_last;
   logic [WIDTH:0]   w_sum, w_diff;
   logic [SHW-1:0]   w_sh;
   logic             w_big;
   logic [2*WIDTH-1:0] w_shl_full, w_rol_full, w_ror_full;
   logic signed [WIDTH-1:0] w_a_s, w_sra;
   logic [WIDTH-1:0] w_res, w_rem;
   logic             w_ovf, w_dz, w_ill;
   logic [WIDTH:0]   w_mul_sum, w_div_trial;
   logic [WIDTH-1:0] w_nhi, w_nlo;

   assign w_a       = bus.MUX_intop;
   assign w_bop     = bus.MUX_inbottom;
   assign w_accept  = (r_state == S_IDLE) && bus.start && !r_halted;
   assign w_iter_op = (bus.CTRL == c_MUL) || ((bus.CTRL == c_DIV) && (|w_bop));
   assign w_last    = (r_cnt == SHW'(WIDTH - 1));

   // Single-cycle datapath, evaluated directly on the live operands at the accepting edge.
   assign w_sum      = {1'b0, w_a} + {1'b0, w_bop};
   assign w_diff     = {1'b0, w_a} - {1'b0, w_bop};
   assign w_sh       = w_bop[SHW-1:0];
   assign w_big      = |w_bop[WIDTH-1:SHW];
   assign w_shl_full = {{WIDTH{1'b0}}, w_a} << w_sh;
   assign w_rol_full = {w_a, w_a} << w_sh;
   assign w_ror_full = {w_a, w_a} >> w_sh;
   assign w_a_s      = w_a;
   assign w_sra      = w_a_s >>> w_sh;

   always_comb begin
      w_res = '0;
      w_rem = '0;
      w_ovf = 1'b0;
      w_dz  = 1'b0;
      w_ill = 1'b0;
      case (bus.CTRL)
         c_ADD: begin
            w_res = w_sum[WIDTH-1:0];
            w_ovf = (w_a[WIDTH-1] == w_bop[WIDTH-1]) && (w_sum[WIDTH-1] != w_a[WIDTH-1]);
         end
         c_SUB: begin
            w_res = w_diff[WIDTH-1:0];
            w_ovf = (w_a[WIDTH-1] != w_bop[WIDTH-1]) && (w_diff[WIDTH-1] != w_a[WIDTH-1]);
         end
         c_AND: w_res = w_a & w_bop;
         c_OR:  w_res = w_a | w_bop;
         c_MUL: w_res = '0;
         c_DIV: begin
            w_res = '1;
            w_rem = w_a;
            w_dz  = 1'b1;
         end
         c_SHL: begin
            w_res = w_big ? '0 : w_shl_full[WIDTH-1:0];
            w_ovf = w_big ? (|w_a) : (|w_shl_full[2*WIDTH-1:WIDTH]);
         end
         c_SRA:  w_res = w_big ? {WIDTH{w_a[WIDTH-1]}} : w_sra;
         c_ROL:  w_res = w_rol_full[2*WIDTH-1:WIDTH];
         c_ROR:  w_res = w_ror_full[WIDTH-1:0];
         c_HALT: w_res = '0;
         default: w_ill = 1'b1;
      endcase
   end

   // One iteration step: r_hi/r_lo hold the product halves for MUL, or partial remainder/quotient for DIV.
   assign w_mul_sum   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b} : '0);
   assign w_div_trial = {r_hi, r_lo[WIDTH-1]} - {1'b0, r_b};

   always_comb begin
      w_nhi = r_hi;
      w_nlo = r_lo;
      if (r_is_mul) begin
         w_nhi = w_mul_sum[WIDTH:1];
         w_nlo = {w_mul_sum[0], r_lo[WIDTH-1:1]};
      end else if (!w_div_trial[WIDTH]) begin
         w_nhi = w_div_trial[WIDTH-1:0];
         w_nlo = {r_lo[WIDTH-2:0], 1'b1};
      end else begin
         w_nhi = {r_hi[WIDTH-2:0], r_lo[WIDTH-1]};
         w_nlo = {r_lo[WIDTH-2:0], 1'b0};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE: begin
            if (w_accept && w_iter_op)               w_next = S_ITER;
            else if (w_accept && bus.CTRL == c_HALT) w_next = S_HALTED;
         end
         S_ITER:   if (w_last) w_next = S_IDLE;
         S_HALTED: w_next = S_HALTED;
         default:  w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_result <= '0;
         r_rem    <= '0;
         r_ovf    <= 1'b0;
         r_dz     <= 1'b0;
         r_ill    <= 1'b0;
         r_halted <= 1'b0;
         r_done   <= 1'b0;
         r_is_mul <= 1'b0;
         r_b      <= '0;
         r_hi     <= '0;
         r_lo     <= '0;
         r_cnt    <= '0;
      end else begin
         r_done <= 1'b0;
         if (w_accept) begin
            if (w_iter_op) begin
               r_is_mul <= (bus.CTRL == c_MUL);
               r_b      <= w_bop;
               r_hi     <= '0;
               r_lo     <= w_a;
               r_cnt    <= '0;
            end else begin
               r_result <= w_res;
               r_rem    <= w_rem;
               r_ovf    <= w_ovf;
               r_dz     <= w_dz;
               r_ill    <= w_ill;
               r_done   <= 1'b1;
               if (bus.CTRL == c_HALT) r_halted <= 1'b1;
            end
         end else if (r_state == S_ITER) begin
            r_hi  <= w_nhi;
            r_lo  <= w_nlo;
            r_cnt <= r_cnt + SHW'(1);
            if (w_last) begin
               r_result <= w_nlo;
               r_rem    <= w_nhi;
               r_ovf    <= r_is_mul && (|w_nhi);
               r_dz     <= 1'b0;
               r_ill    <= 1'b0;
               r_done   <= 1'b1;
            end
         end
      end
   end

   assign bus.busy          = (r_state == S_ITER);
   assign bus.done          = r_done;
   assign bus.ALU_Result    = r_result;
   assign bus.Remainder     = r_rem;
   assign bus.Overflow_flag = r_ovf;
   assign bus.DivZero_flag  = r_dz;
   assign bus.Illegal_flag  = r_ill;
   assign bus.Halted        = r_halted;

endmodule

`default_nettype wire

// File: tb/tb_seq_alu.sv
// ============================================================================
// Module   : tb_seq_alu
// Brief    : Directed self-checking bench for seq_alu (WIDTH = 16).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_seq_alu;

   logic clk;
   logic rst_n;
   int   n_assert;
   int   n_fail;
   int   lat;
   int   nbusy;
   int   ndone;

   seq_alu_if #(.WIDTH(16)) bus ();

   seq_alu #(.WIDTH(16)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Issue one op, scramble the operands after the accepting edge, optionally pulse
   // a stray start at cycle 'poke', and count cycles until done (bounded).
   task automatic run(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                      input int poke, output int l, output int nb);
      @(negedge clk);
      bus.CTRL = op; bus.MUX_intop = a; bus.MUX_inbottom = b; bus.start = 1'b1;
      @(posedge clk);
      #1;
      bus.start = 1'b0; bus.MUX_intop = ~a; bus.MUX_inbottom = ~b; bus.CTRL = 4'd0;
      l = 0; nb = 0;
      while (l < 40) begin
         @(negedge clk);
         l++;
         bus.start = (l == poke);
         if (bus.busy) nb++;
         if (bus.done) break;
      end
      bus.start = 1'b0;
   endtask

   task automatic single(input string tag, input logic [3:0] op, input logic [15:0] a,
                         input logic [15:0] b, input logic [15:0] res, input logic ovf);
      run(op, a, b, 0, lat, nbusy);
      chk({tag, "_lat"}, lat, 1);
      chk({tag, "_res"}, bus.ALU_Result, res);
      chk({tag, "_ovf"}, bus.Overflow_flag, ovf);
   endtask

   initial begin
      n_assert = 0; n_fail = 0;
      rst_n = 1'b0;
      bus.start = 1'b0; bus.CTRL = 4'd0; bus.MUX_intop = '0; bus.MUX_inbottom = '0;
      repeat (3) @(negedge clk);
      chk("rst_res",  bus.ALU_Result, 0);
      chk("rst_done", bus.done, 0);
      chk("rst_busy", bus.busy, 0);
      chk("rst_halt", bus.Halted, 0);
      rst_n = 1'b1;

      single("add",    4'd0, 16'd1000,  16'd50, 16'd1050,  1'b0);
      chk("add_rem", bus.Remainder, 0);
      single("sub",    4'd1, 16'd1000,  16'd50, 16'd950,   1'b0);
      single("addovf", 4'd0, 16'd32767, 16'd1,  16'd32768, 1'b1);
      single("and",    4'd2, 16'd1000,  16'd50, 16'd32,    1'b0);
      single("or",     4'd3, 16'd1000,  16'd50, 16'd1018,  1'b0);

      run(4'd4, 16'd32000, 16'd5, 6, lat, nbusy);
      chk("mul_lat",  lat, 17);
      chk("mul_busy", nbusy, 16);
      chk("mul_res",  bus.ALU_Result, 28928);
      chk("mul_rem",  bus.Remainder, 2);
      chk("mul_ovf",  bus.Overflow_flag, 1);
      @(negedge clk);
      chk("mul_nodone2", bus.done, 0);
      chk("mul_hold", bus.ALU_Result, 28928);

      run(4'd5, 16'd25, 16'd6, 0, lat, nbusy);
      chk("div_lat", lat, 17);
      chk("div_res", bus.ALU_Result, 4);
      chk("div_rem", bus.Remainder, 1);
      chk("div_dz",  bus.DivZero_flag, 0);
      chk("div_ovf", bus.Overflow_flag, 0);

      run(4'd5, 16'd25, 16'd0, 0, lat, nbusy);
      chk("dz_lat", lat, 1);
      chk("dz_res", bus.ALU_Result, 65535);
      chk("dz_rem", bus.Remainder, 25);
      chk("dz_dz",  bus.DivZero_flag, 1);
      chk("dz_ovf", bus.Overflow_flag, 0);

      single("shl",    4'd6, 16'd18,     16'd1,  16'd36,     1'b0);
      chk("shl_dzclr", bus.DivZero_flag, 0);
      chk("shl_remclr", bus.Remainder, 0);
      single("sra",    4'd7, 16'd18,     16'd1,  16'd9,      1'b0);
      single("srabig", 4'd7, 16'h8000,   16'd20, 16'hFFFF,   1'b0);
      single("rol",    4'd8, 16'd1000,   16'd50, 16'd4000,   1'b0);
      single("ror",    4'd9, 16'd1000,   16'd50, 16'd250,    1'b0);
      single("shlovf", 4'd6, 16'h8001,   16'd1,  16'd2,      1'b1);

      // Illegal opcode, then an ADD issued in its done cycle.
      @(negedge clk);
      bus.CTRL = 4'd13; bus.MUX_intop = 16'd7; bus.MUX_inbottom = 16'd9; bus.start = 1'b1;
      @(posedge clk);
      #1 bus.start = 1'b0;
      @(negedge clk);
      chk("ill_done", bus.done, 1);
      chk("ill_flag", bus.Illegal_flag, 1);
      chk("ill_res",  bus.ALU_Result, 0);
      bus.CTRL = 4'd0; bus.MUX_intop = 16'd5; bus.MUX_inbottom = 16'd6; bus.start = 1'b1;
      @(posedge clk);
      #1 bus.start = 1'b0;
      @(negedge clk);
      chk("b2b_done", bus.done, 1);
      chk("b2b_res",  bus.ALU_Result, 11);
      chk("b2b_ill",  bus.Illegal_flag, 0);

      // Reset during MUL iteration.
      @(negedge clk);
      bus.CTRL = 4'd4; bus.MUX_intop = 16'd300; bus.MUX_inbottom = 16'd300; bus.start = 1'b1;
      @(posedge clk);
      #1 bus.start = 1'b0;
      repeat (8) @(negedge clk);
      chk("rstmid_busy_before", bus.busy, 1);
      rst_n = 1'b0;
      #1;
      chk("rstmid_res",  bus.ALU_Result, 0);
      chk("rstmid_busy", bus.busy, 0);
      chk("rstmid_done", bus.done, 0);
      @(negedge clk);
      rst_n = 1'b1;
      ndone = 0;
      repeat (20) begin
         @(negedge clk);
         if (bus.done) ndone++;
      end
      chk("rstmid_nodone", ndone, 0);
      single("postrst", 4'd0, 16'd3, 16'd4, 16'd7, 1'b0);

      // HALT is sticky; later starts are ignored.
      run(4'd10, 16'd123, 16'd45, 0, lat, nbusy);
      chk("halt_lat", lat, 1);
      chk("halt_flag", bus.Halted, 1);
      chk("halt_res", bus.ALU_Result, 0);
      @(negedge clk);
      bus.CTRL = 4'd0; bus.MUX_intop = 16'd1; bus.MUX_inbottom = 16'd1; bus.start = 1'b1;
      ndone = 0;
      repeat (20) begin
         @(negedge clk);
         if (bus.done) ndone++;
      end
      bus.start = 1'b0;
      chk("halt_nodone", ndone, 0);
      chk("halt_sticky", bus.Halted, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
